sram_axil_slave: RTL

Parametrised AXI4-Lite SRAM slave: a single-port word memory behind independent write (AW/W/B) and read (AR/R) channels with full ready/valid backpressure, byte-lane write strobes and optional address range checking. Successor to the fixed 32-bit, 256-word, always-ready SRAM slave. Used as on-chip scratch/register memory on the AXI4-Lite peripheral interconnect and as the DUT for the AXI-Lite UVM environment.

---
 rtl/sram_axil_slave_if.sv | 43 ++++
 rtl/sram_axil_slave.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sram_axil_slave_if.sv
// AXI4-Lite bus bundle for sram_axil_slave.
// Carries the write address (AW), write data (W), write response (B),
// read address (AR) and read data (R) channels. ACLK and ARESETn stay
// outside the bundle as plain ports.
// Modports:
//   master - drives the addresses, data, strobes, VALIDs and the B/R READYs.
//   slave  - drives the AW/W/AR READYs, the responses and the B/R VALIDs.
interface sram_axil_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/sram_axil_slave.sv
// AXI4-Lite SRAM slave: a single-port word memory behind independent write
// (AW/W/B) and read (AR/R) channels, with byte-lane strobes and full
// ready/valid backpressure.
// Ports:
//   ACLK     - clock, rising edge
//   ARESETn  - asynchronous active-low reset
//   bus      - sram_axil_slave_if.slave (AW, W, B, AR, R channels)
// Parameters: DATA_W (32/64), DEPTH (words, power of two), ADDR_W (byte address).
// Optional feature macro: SRAM_AXIL_RANGE_CHECK_EN
//   defined   - addresses at or above DEPTH*STRB_W get SLVERR; writes are
//               dropped and reads return zero.
//   undefined - upper address bits are ignored and the address wraps.
module sram_axil_slave #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input logic              ACLK,
    input logic              ARESETn,
    sram_axil_slave_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned OFS_W  = $clog2(STRB_W);
    localparam int unsigned HI_LSB = OFS_W + IDX_W;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_t;

    wstate_t           wstate_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  wa_idx_q;
    logic              wa_oor_q;
    logic [DATA_W-1:0] wd_q;
    logic [STRB_W-1:0] ws_q;

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              aw_hs_c;
    logic              w_hs_c;
    logic              ar_hs_c;
    logic [IDX_W-1:0]  aw_idx_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic              aw_oor_c;
    logic              ar_oor_c;
    logic              unused_addr_bits_c;

    logic              commit_c;
    logic [IDX_W-1:0]  c_idx_c;
    logic              c_oor_c;
    logic [DATA_W-1:0] c_data_c;
    logic [STRB_W-1:0] c_strb_c;

    // Handshakes use only registered READYs, so no VALID->READY path exists.
    assign aw_hs_c  = bus.AWVALID && awready_q;
    assign w_hs_c   = bus.WVALID && wready_q;
    assign ar_hs_c  = bus.ARVALID && !rvalid_q;

    // Word index; the low byte-offset bits are dropped (unaligned rounds down).
    assign aw_idx_c = bus.AWADDR[OFS_W +: IDX_W];
    assign ar_idx_c = bus.ARADDR[OFS_W +: IDX_W];

`ifdef SRAM_AXIL_RANGE_CHECK_EN
    // Any set bit above the memory span marks the access out of range.
    assign aw_oor_c = |bus.AWADDR[ADDR_W-1:HI_LSB];
    assign ar_oor_c = |bus.ARADDR[ADDR_W-1:HI_LSB];
    assign unused_addr_bits_c = &{1'b0, bus.AWADDR[OFS_W-1:0], bus.ARADDR[OFS_W-1:0]};
`else
    // Upper bits ignored: addresses wrap modulo DEPTH words.
    assign aw_oor_c = 1'b0;
    assign ar_oor_c = 1'b0;
    assign unused_addr_bits_c = &{1'b0, bus.AWADDR[OFS_W-1:0], bus.ARADDR[OFS_W-1:0],
                                  bus.AWADDR[ADDR_W-1:HI_LSB], bus.ARADDR[ADDR_W-1:HI_LSB]};
`endif

    // Commit select: whichever half completes this edge merges with the latched half.
    always_comb begin
        commit_c = 1'b0;
        c_idx_c  = aw_idx_c;
        c_oor_c  = aw_oor_c;
        c_data_c = bus.WDATA;
        c_strb_c = bus.WSTRB;
        case (wstate_q)
            W_IDLE: commit_c = aw_hs_c && w_hs_c;
            W_ADDR: begin
                commit_c = w_hs_c;
                c_idx_c  = wa_idx_q;
                c_oor_c  = wa_oor_q;
            end
            W_DATA: begin
                commit_c = aw_hs_c;
                c_data_c = wd_q;
                c_strb_c = ws_q;
            end
            default: commit_c = 1'b0;
        endcase
    end

    // Write FSM with registered READY/BVALID/BRESP outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wa_idx_q  <= '0;
            wa_oor_q  <= 1'b0;
            wd_q      <= '0;
            ws_q      <= '0;
        end else if (commit_c) begin
            wstate_q  <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= c_oor_c ? 2'b10 : 2'b00;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs_c) begin
                        wstate_q  <= W_ADDR;
                        awready_q <= 1'b0;
                        wa_idx_q  <= aw_idx_c;
                        wa_oor_q  <= aw_oor_c;
                    end else if (w_hs_c) begin
                        wstate_q  <= W_DATA;
                        wready_q  <= 1'b0;
                        wd_q      <= bus.WDATA;
                        ws_q      <= bus.WSTRB;
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        wstate_q  <= W_IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        bvalid_q  <= 1'b0;
                    end
                end
                default: wstate_q <= wstate_q;
            endcase
        end
    end

    // Memory array: byte-lane write, no reset.
    always_ff @(posedge ACLK) begin
        if (commit_c && !c_oor_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (c_strb_c[i]) begin
                    mem[c_idx_c][8*i +: 8] <= c_data_c[8*i +: 8];
                end
            end
        end
    end

    // Read path: one outstanding read; the array read sees pre-write contents.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs_c) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_oor_c ? '0 : mem[ar_idx_c];
            rresp_q  <= ar_oor_c ? 2'b10 : 2'b00;
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = !rvalid_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
endmodule
